// File: rtl/auction_bid_collector_if.sv
// rtl/auction_bid_collector_if.sv - bid stream in, packed bid vector out
// Purpose: bundles the inbound bid stream and the outbound bid-vector handshake.
// Signals: in_valid/in_ready/in_id/in_bid (bid stream), bid/out_valid/out_ready (vector out).
// Modports: slave = collector side, master = producer/consumer side.
interface auction_bid_collector_if #(
    parameter int N = 2,
    parameter int W = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          in_id;
    logic [W-1:0]          in_bid;
    logic [(2**N)*W-1:0]   bid;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_id, in_bid, out_ready,
        output in_ready, bid, out_valid
    );

    modport master (
        output in_valid, in_id, in_bid, out_ready,
        input  in_ready, bid, out_valid
    );
endinterface

// File: rtl/auction_bid_collector.sv
// rtl/auction_bid_collector.sv - sealed-bid collector, one bid per bidder, timeout close
// Purpose: gathers one bid per bidder, closes the round when all have bid or on timeout,
//          then presents the packed bid vector until the auction stage takes it.
// Ports: clk, rst (sync active-low), start, bus (auction_bid_collector_if.slave),
//        received (per-bidder stored flags), dup_err (registered pulse), timed_out.
module auction_bid_collector #(
    parameter int N       = 2,
    parameter int W       = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    auction_bid_collector_if.slave  bus,
    output logic [2**N-1:0]         received,
    output logic                    dup_err,
    output logic                    timed_out
);
    localparam int NB = 2**N;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t          state;
    state_t          state_next;
    logic [NB*W-1:0] bid_r;
    logic [TW-1:0]   timer;

    logic            accept;
    logic            is_dup;
    logic [NB-1:0]   received_upd;
    logic            all_in;
    logic            timer_expired;

    assign accept        = (state == COLLECT) && bus.in_valid;
    assign is_dup        = received[bus.in_id];
    // received as it will be after this edge; drives the "everyone has bid" exit
    assign received_upd  = received | (accept ? (NB'(1) << bus.in_id) : '0);
    assign all_in        = &received_upd;
    assign timer_expired = (timer == TW'(TIMEOUT - 1));
    assign bus.bid       = bid_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                bus.in_ready = 1'b1;
                // completion wins over timeout when both land on the same edge
                if (all_in || timer_expired) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bid_r     <= '0;
            received  <= '0;
            timer     <= '0;
            dup_err   <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bid_r     <= '0;
                        received  <= '0;
                        timer     <= '0;
                        timed_out <= 1'b0;
                    end
                end
                COLLECT: begin
                    timer    <= timer + 1'b1;
                    received <= received_upd;
                    for (int i = 0; i < NB; i++) begin
                        // first bid stands; a repeat only raises dup_err
                        if (accept && !is_dup && (bus.in_id == N'(i))) begin
                            bid_r[i*W +: W] <= bus.in_bid;
                        end
                    end
                    if (accept && is_dup) begin
                        dup_err <= 1'b1;
                    end
                    if (!all_in && timer_expired) begin
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_auction_bid_collector.sv
// tb/tb_auction_bid_collector.sv - directed scoreboard bench for auction_bid_collector
module tb_auction_bid_collector;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] received;
    logic       dup_err;
    logic       timed_out;

    auction_bid_collector_if #(.N(2), .W(2)) bus ();

    auction_bid_collector #(.N(2), .W(2), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus.slave),
        .received  (received),
        .dup_err   (dup_err),
        .timed_out (timed_out)
    );

    typedef struct packed {
        logic [7:0] bid;
        logic [3:0] rcv;
        logic       to;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_bid;
    logic [3:0] m_rcv;
    int         passed = 0;
    int         total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic begin_round();
        start = 1'b1;
        step();
        start = 1'b0;
        m_bid = '0;
        m_rcv = '0;
        chk("in_ready_collect", bus.in_ready, 1'b1);
    endtask

    task automatic send(input int id, input int val);
        logic       exp_dup;
        logic [1:0] idb;
        logic [1:0] vb;
        idb = id[1:0];
        vb  = val[1:0];
        bus.in_valid = 1'b1;
        bus.in_id    = idb;
        bus.in_bid   = vb;
        exp_dup = m_rcv[idb];
        if (!exp_dup) begin
            m_bid[idb*2 +: 2] = vb;
            m_rcv[idb]        = 1'b1;
        end
        step();
        bus.in_valid = 1'b0;
        chk("dup_err", dup_err, exp_dup);
    endtask

    task automatic close_round();
        exp_t e;
        e.bid = m_bid;
        e.rcv = m_rcv;
        e.to  = ~&m_rcv;
        sb.push_back(e);
    endtask

    task automatic check_out();
        int   n;
        exp_t e;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("hold_reached", bus.out_valid, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("bid_vec", bus.bid, e.bid);
            chk("received", received, e.rcv);
            chk("timed_out", timed_out, e.to);
            chk("in_ready_hold", bus.in_ready, 1'b0);
        end
    endtask

    task automatic release_hold();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("idle_out_valid", bus.out_valid, 1'b0);
        chk("idle_in_ready", bus.in_ready, 1'b0);
    endtask

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_id     = '0;
        bus.in_bid    = '0;
        bus.out_ready = 1'b0;
        m_bid         = '0;
        m_rcv         = '0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_bid", bus.bid, 8'h00);
        chk("rst_received", received, 4'h0);
        chk("rst_dup_err", dup_err, 1'b0);
        chk("rst_timed_out", timed_out, 1'b0);
        rst = 1'b1;
        step();
        chk("idle_no_start", bus.in_ready, 1'b0);

        // full round on consecutive cycles
        begin_round();
        send(0, 1);
        send(1, 3);
        send(2, 2);
        send(3, 0);
        chk("latency_full", bus.out_valid, 1'b1);
        chk("bid_full_const", bus.bid, 8'b00_10_11_01);
        close_round();
        check_out();
        release_hold();

        // duplicate from bidder 1
        begin_round();
        send(0, 1);
        send(1, 3);
        send(1, 2);
        send(2, 2);
        send(3, 0);
        chk("bid_dup_const", bus.bid, 8'b00_10_11_01);
        close_round();
        check_out();
        release_hold();

        // timeout with only bidders 0 and 2
        begin_round();
        send(0, 2);
        send(2, 1);
        repeat (5) step();
        chk("timeout_not_yet", bus.out_valid, 1'b0);
        step();
        chk("timeout_at_8", bus.out_valid, 1'b1);
        chk("bid_to_const", bus.bid, 8'b00_01_00_10);
        close_round();
        check_out();
        release_hold();

        // last bid on the 8th COLLECT cycle
        begin_round();
        send(0, 3);
        send(1, 1);
        send(2, 0);
        repeat (4) step();
        chk("late_not_yet", bus.out_valid, 1'b0);
        send(3, 2);
        close_round();
        check_out();

        // HOLD is stable against start / in_valid while out_ready=0
        for (int i = 0; i < 5; i++) begin
            start        = i[0];
            bus.in_valid = ~i[0];
            bus.in_id    = 2'd0;
            bus.in_bid   = 2'd0;
            step();
            chk("hold_bid", bus.bid, 8'b10_00_01_11);
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_valid", bus.out_valid, 1'b1);
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        release_hold();

        // reset midway through COLLECT
        begin_round();
        send(0, 1);
        send(1, 2);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_id    = 2'd2;
        bus.in_bid   = 2'd3;
        step();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        chk("abort_in_ready", bus.in_ready, 1'b0);
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_bid", bus.bid, 8'h00);
        chk("abort_received", received, 4'h0);
        chk("abort_dup", dup_err, 1'b0);
        chk("abort_to", timed_out, 1'b0);

        // clean round after abort
        begin_round();
        send(3, 1);
        send(2, 1);
        send(1, 0);
        send(0, 3);
        chk("bid_after_abort", bus.bid, 8'b01_01_00_11);
        close_round();
        check_out();
        release_hold();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/auction_bid_collector.md
Name: auction_bid_collector

Overview:
- Upstream stage of the sealed-bid auction tree.
- Gathers one bid per bidder from a serial valid/ready stream, tagged with a bidder ID. It enforces one bid per bidder and closes the round when all bidders have bid or a timeout expires.
- Presents the packed bid vector, bidder i in bits [(i+1)*W-1:i*W], to the auction stage under a valid/ready handshake.

Parameters:
- N, 2, log2 of bidder count (2**N bidders); bidder ID width.
- W, 2, bid width in bits.
- TIMEOUT, 8, maximum cycles spent in COLLECT before a forced close (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- start  input  1  opens a new bidding round; honoured only in IDLE.
- in_valid  input  1  bid present on in_id/in_bid.
- in_ready  output  1  collector accepts a bid this cycle.
- in_id  input  N  bidder index.
- in_bid  input  W  bid value (unsigned).
- bid  output  (2**N)*W  packed bid vector to the auction stage.
- out_valid  output  1  bid vector complete and stable.
- out_ready  input  1  auction stage consumes the vector.
- received  output  2**N  bit i set once bidder i's bid has been stored.
- dup_err  output  1  one-cycle pulse: an accepted bid came from a bidder already in received.
- timed_out  output  1  high in HOLD when the round closed by timeout with received not all ones.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, bid=0, received=0, timer=0, and in_ready, out_valid, dup_err, timed_out all 0. Reset overrides every other input and aborts any round in progress.
- FSM states are IDLE, COLLECT and HOLD.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> COLLECT next cycle; bid, received, timer and timed_out cleared in that same edge.
- COLLECT:
  - in_ready=1. Accept = in_valid & in_ready.
  - On accept with received[in_id]=0: store in_bid into slot in_id and set received[in_id].
  - On accept with received[in_id]=1: slot unchanged (first bid stands); dup_err=1 for the cycle after the edge; the timer still advances.
  - The timer increments every COLLECT cycle.
- COLLECT exits:
  - If the accept on this edge makes received all ones -> HOLD; timed_out=0.
  - Else if timer==TIMEOUT-1 -> HOLD; timed_out=1. A bid accepted on that same edge is still stored; missing slots remain 0.
  - The all-ones condition takes priority when both hold on the same edge (timed_out=0).
- HOLD:
  - in_ready=0, out_valid=1.
  - bid, received and timed_out are held stable.
  - out_ready=1 -> IDLE next cycle. bid and received keep their values until the next start clears them.
- start is ignored in COLLECT and HOLD.
- in_valid is ignored outside COLLECT.
- in_id is always within range, because the ID is exactly N bits.
- Latency: the best case is 2**N accepts on consecutive cycles, so out_valid rises at the first edge after the last accept.
- Timeout bound: COLLECT lasts at most TIMEOUT cycles.
- Timer width is clog2(TIMEOUT)+1 bits; no wrap within a round.
- dup_err is registered and is 0 in every cycle without a duplicate accept.

Test Plan:
- N=2,W=2,TIMEOUT=8. Reset, start, then bids (id,bid) = (0,1),(1,3),(2,2),(3,0) on consecutive cycles -> out_valid high the cycle after the 4th accept; bid=8'b00_10_11_01; received=4'hF; timed_out=0.
- Same, but (1,3) then (1,2) -> dup_err pulses once; slot1 stays 3; round still completes after ids 0,2,3 arrive.
- Only ids 0 and 2 bid (values 2,1) -> HOLD after exactly 8 COLLECT cycles; bid=8'b00_01_00_10; received=4'b0101; timed_out=1.
- Last missing bid arrives on the 8th COLLECT cycle -> bid stored; received=4'hF; timed_out=0.
- In HOLD, hold out_ready=0 for 5 cycles, and pulse start and in_valid meanwhile -> bid unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
- Assert rst=0 midway through COLLECT with 2 bids stored -> next cycle: IDLE, bid=0, received=0, all outputs 0; a new start runs a clean round.
